// File: rtl/mac_dot_ctrl.sv
// Dot-product sequencer: clears, multiplies and accumulates len operand pairs, then pulses done.
// Optional macro MAC_DOT_SAT_EN selects saturating accumulation instead of wrapping.
module mac_dot_ctrl #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 16,
   parameter int LEN_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              done,
   output logic [ACC_W-1:0]  result,
   output logic              overflow
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t              state_reg, state_next;
   logic [ACC_W-1:0]    acc_reg, acc_next;
   logic [LEN_W-1:0]    cnt_reg, len_reg, cnt_inc;
   logic                ovf_reg;
   logic                accept, beat;
   logic [2*DATA_W-1:0] product;
   logic [ACC_W:0]      sum;

   assign cnt_inc = cnt_reg + {{(LEN_W-1){1'b0}}, 1'b1};

   always_comb begin
      state_next = state_reg;
      busy       = 1'b0;
      in_ready   = 1'b0;
      done       = 1'b0;
      accept     = 1'b0;
      beat       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = (len == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            busy     = 1'b1;
            in_ready = 1'b1;
            beat     = in_valid;
            if (in_valid && (cnt_inc == len_reg))
               state_next = DONE;
         end
         DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // One spare bit above the accumulator captures the carry used for overflow.
   assign product = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
   assign sum     = {1'b0, acc_reg} + {{(ACC_W+1-2*DATA_W){1'b0}}, product};

`ifdef MAC_DOT_SAT_EN
   assign acc_next = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
   assign acc_next = sum[ACC_W-1:0];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         acc_reg   <= '0;
         cnt_reg   <= '0;
         len_reg   <= '0;
         ovf_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            acc_reg <= '0;
            cnt_reg <= '0;
            len_reg <= len;
            ovf_reg <= 1'b0;
         end else if (beat) begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_inc;
            if (sum[ACC_W])
               ovf_reg <= 1'b1;
         end
      end
   end

   assign result   = acc_reg;
   assign overflow = ovf_reg;

endmodule

// File: tb/tb_mac_dot_ctrl.sv
// Directed-vector bench for mac_dot_ctrl with hand-computed expected sums.
// Honours MAC_DOT_SAT_EN for the overflow expectation.
module tb_mac_dot_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  len = '0;
   logic        busy;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  a = '0;
   logic [7:0]  b = '0;
   logic        done;
   logic [15:0] result;
   logic        overflow;

   int vectors = 0;
   int miscompares = 0;

`ifdef MAC_DOT_SAT_EN
   localparam int OVF_RESULT = 65535;
`else
   localparam int OVF_RESULT = 64514;
`endif

   logic [7:0] va [4] = '{8'd5, 8'd3, 8'd7, 8'd8};
   logic [7:0] vb [4] = '{8'd2, 8'd4, 8'd9, 8'd6};

   mac_dot_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
      .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .done(done), .result(result), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [3:0] n);
      start = 1'b1;
      len   = n;
      step();
      start = 1'b0;
   endtask

   task automatic send(input logic [7:0] x, input logic [7:0] y);
      in_valid = 1'b1;
      a = x;
      b = y;
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      step();
      step();
      check_val("rst_busy", busy, 0);
      check_val("rst_ready", in_ready, 0);
      check_val("rst_done", done, 0);
      check_val("rst_result", result, 0);
      check_val("rst_ovf", overflow, 0);
      rst = 1'b0;
      step();

      // basic back-to-back
      do_start(4'd4);
      check_val("basic_busy", busy, 1);
      check_val("basic_ready", in_ready, 1);
      for (int i = 0; i < 4; i++) begin
         check_val("basic_nodone", done, 0);
         send(va[i], vb[i]);
      end
      check_val("basic_done", done, 1);
      check_val("basic_result", result, 133);
      check_val("basic_ovf", overflow, 0);
      check_val("basic_ready_off", in_ready, 0);
      $display("op basic: result=%0d overflow=%0d", result, overflow);
      step();
      check_val("basic_done_pulse", done, 0);
      check_val("basic_idle", busy, 0);
      check_val("basic_hold", result, 133);

      // bubbles between beats
      do_start(4'd4);
      for (int i = 0; i < 4; i++) begin
         send(va[i], vb[i]);
         if (i < 3) begin
            for (int j = 0; j < 2; j++) begin
               step();
               check_val("bub_ready", in_ready, 1);
               check_val("bub_nodone", done, 0);
            end
         end
      end
      check_val("bub_done", done, 1);
      check_val("bub_result", result, 133);
      $display("op bubbles: result=%0d", result);
      step();

      // zero length
      do_start(4'd0);
      check_val("zero_done", done, 1);
      check_val("zero_result", result, 0);
      check_val("zero_ready", in_ready, 0);
      check_val("zero_ovf", overflow, 0);
      $display("op zero: result=%0d", result);
      step();
      check_val("zero_done_pulse", done, 0);
      check_val("zero_idle", busy, 0);

      // overflow
      do_start(4'd2);
      send(8'd255, 8'd255);
      check_val("ovf_first", overflow, 0);
      send(8'd255, 8'd255);
      check_val("ovf_done", done, 1);
      check_val("ovf_result", result, OVF_RESULT);
      check_val("ovf_flag", overflow, 1);
      $display("op overflow: result=%0d overflow=%0d", result, overflow);
      step();
      check_val("ovf_sticky", overflow, 1);
      do_start(4'd1);
      check_val("ovf_cleared", overflow, 0);
      send(8'd1, 8'd1);
      check_val("ovf_next_result", result, 1);
      check_val("ovf_next_flag", overflow, 0);
      step();

      // start ignored while busy, in_valid ignored while idle
      do_start(4'd2);
      start = 1'b1;
      len = 4'd1;
      send(8'd2, 8'd3);
      start = 1'b0;
      check_val("busy_run_ready", in_ready, 1);
      check_val("busy_run_nodone", done, 0);
      send(8'd4, 8'd5);
      check_val("busy_done", done, 1);
      check_val("busy_result", result, 26);
      start = 1'b1;
      len = 4'd1;
      step();
      start = 1'b0;
      check_val("busy_done_start_busy", busy, 0);
      check_val("busy_done_start_ready", in_ready, 0);
      send(8'd9, 8'd9);
      check_val("idle_valid_result", result, 26);
      check_val("idle_valid_done", done, 0);
      $display("op busy: result=%0d", result);

      // reset mid-operation
      do_start(4'd4);
      send(8'd5, 8'd2);
      send(8'd3, 8'd4);
      check_val("abort_partial", result, 22);
      rst = 1'b1;
      #1;
      check_val("abort_busy", busy, 0);
      check_val("abort_ready", in_ready, 0);
      check_val("abort_done", done, 0);
      check_val("abort_result", result, 0);
      check_val("abort_ovf", overflow, 0);
      in_valid = 1'b1;
      a = 8'd1;
      b = 8'd1;
      step();
      step();
      in_valid = 1'b0;
      rst = 1'b0;
      step();
      check_val("abort_no_done", done, 0);
      check_val("abort_idle_result", result, 0);
      do_start(4'd1);
      send(8'd3, 8'd4);
      check_val("fresh_done", done, 1);
      check_val("fresh_result", result, 12);
      $display("op after reset: result=%0d", result);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mac_dot_ctrl.md
# mac_dot_ctrl

Dot-product sequencer for the 8x8 -> 16-bit multiply-accumulate datapath. It accepts a start command with a vector length and streams operand pairs through a valid/ready handshake. It clears the accumulator, multiplies and accumulates each accepted pair, and reports the final sum with a one-cycle done pulse. It sits between a requester (a DMA or a host register interface) and the MAC arithmetic, so nothing upstream uses reset to clear the accumulator.

## Interface
- DATA_W, 8, operand width (a, b)
- ACC_W, 16, accumulator/result width
- LEN_W, 4, vector length field width (max length 2^LEN_W-1)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a new dot product; sampled only in IDLE
- len  in  LEN_W  number of pairs; sampled with start
- busy  out  1  high in RUN and DONE
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts a pair this cycle
- a  in  DATA_W  operand A, unsigned
- b  in  DATA_W  operand B, unsigned
- done  out  1  one-cycle pulse: result valid
- result  out  ACC_W  final sum; held until next accepted start
- overflow  out  1  sticky per operation; accumulation exceeded 2^ACC_W-1

## Operation
- The state machine has three states: IDLE, RUN, DONE.
- IDLE -> RUN when start=1 and len!=0. On that edge the accumulator and beat counter clear, len is latched, and overflow clears.
- IDLE -> DONE when start=1 and len=0. The accumulator clears, so result=0 and overflow=0.
- RUN: in_ready=1. A beat is in_valid&&in_ready. Each beat does acc <= acc + a*b and increments the counter.
- RUN -> DONE on the edge accepting beat number len. No more pairs are accepted in that operation.
- DONE: done=1, in_ready=0. Unconditionally -> IDLE next edge.
- start outside IDLE is ignored; it is not queued. in_valid outside RUN is ignored.
- Arithmetic: the product is an unsigned DATA_W x DATA_W -> 2*DATA_W value, zero-extended to ACC_W+1 for the add.
- Without the saturation option, the sum wraps modulo 2^ACC_W. Any carry out of bit ACC_W-1 sets overflow until the next accepted start.
- result is registered and updates with the accumulator. Its value is only meaningful while done=1 or in IDLE after a completed operation.
- in_ready is a registered state decode and has no combinational path from in_valid.

## Timing
- Reset values: state=IDLE, busy=0, in_ready=0, done=0, result=0, overflow=0, acc=0, counter=0.
- start accepted on edge T: busy=1 and in_ready=1 from T through the final beat edge.
- A final beat accepted on edge E gives done=1 during the cycle after E. result includes that beat.
- Back-to-back streaming of len beats takes len cycles of in_ready.
- Minimum start-to-start spacing is len+2 cycles (len=0: 2 cycles).
- Bubbles (in_valid=0) in RUN stall the operation indefinitely with no timeout.
- Reset asserted mid-operation aborts immediately to reset values. No done pulse is produced for the aborted operation.
- start asserted in the same cycle as done is ignored, because the state is DONE.

## Configuration
- MAC_DOT_SAT_EN
- When defined, accumulation saturates. If acc + a*b > 2^ACC_W-1, acc is set to 2^ACC_W-1, overflow sets, and later beats keep acc at the maximum.
- When not defined, accumulation wraps modulo 2^ACC_W and overflow still reports the carry.

## Test plan
- Basic dot product: start, len=4, pairs (5,2),(3,4),(7,9),(8,6) streamed back-to-back -> done pulses one cycle after the 4th beat edge, result=133, overflow=0.
- Bubbles: same vectors with in_valid low for 2 cycles between beats -> result=133. done appears only after the 4th accepted beat. in_ready stays 1 throughout RUN.
- Zero length: start with len=0 -> done one cycle later, result=0, in_ready never asserts.
- Overflow: len=2, pairs (255,255),(255,255) -> without MAC_DOT_SAT_EN: result=64514 (0xFC02), overflow=1. With the macro: result=65535, overflow=1. The next start clears overflow.
- Busy behaviour: start re-asserted during RUN, and again in the done cycle, with len=1 -> ignored, and the current result is unaffected. in_valid pulses while IDLE are not accumulated.
- Reset mid-operation: rst pulsed after 2 of 4 beats -> all outputs at reset values, no done. A fresh start with len=1 and pair (3,4) then gives result=12.
